rf_writeback: RTL and testbench
===============================

Name: rf_writeback

Overview:
- Write-side master for the 32x32 register file.
- Merges two result streams into the single regfile write port (we/wa/wd):
  - ALU results: single-cycle, no backpressure, always win the port.
  - Load (MEM) results: buffered in a small FIFO and drained in idle slots.
- Tracks pending load destinations so decode can stall on RAW hazards.
- Kills stale queued loads on WAW.

Parameters:
- DEPTH, 4, load FIFO entries; power of 2, at least 2.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result present this cycle; always accepted.
- alu_rd  in  AW  ALU destination register.
- alu_data  in  DW  ALU result.
- mem_valid  in  1  load result offered.
- mem_ready  out  1  FIFO can accept; equals !full, from registered count only.
- mem_rd  in  AW  load destination register.
- mem_data  in  DW  load data.
- rf_we  out  1  regfile write enable (registered).
- rf_wa  out  AW  regfile write address (registered).
- rf_wd  out  DW  regfile write data (registered).
- q_ra1, q_ra2  in  AW  decode hazard query addresses.
- q_busy1, q_busy2  out  1  a live queued load targets q_raN (combinational).

Behaviour:
- Reset (async, rst_n=0):
  - rf_we=0, rf_wa=0, rf_wd=0.
  - FIFO empty, all entry valid bits 0, mem_ready=1.
  - Reset mid-drain discards all queued loads.
- Latency: a selected source in cycle t appears on rf_* after the edge ending cycle t, so the regfile commits it at the following edge.
- Port selection, evaluated every cycle:
  - If alu_valid and alu_rd!=0: ALU takes the slot; rf_we=1, rf_wa=alu_rd, rf_wd=alu_data. FIFO does not pop.
  - Otherwise, if the FIFO is non-empty: pop the head.
    - Live head: rf_we=1, rf_wa/rf_wd from the head.
    - Killed head: rf_we=0, slot consumed.
  - Otherwise rf_we=0, and rf_wa/rf_wd hold their previous values.
- x0 handling:
  - rf_we is never 1 with rf_wa=0.
  - alu_valid with alu_rd=0 is treated as idle.
  - mem handshake with mem_rd=0 completes but nothing is enqueued.
- Push: on mem_valid && mem_ready && mem_rd!=0, the entry is written at the tail with live=1.
  - Push and pop may occur in the same cycle.
  - mem_ready is based on pre-cycle count, so a same-cycle pop never raises ready.
- WAW kill: when the ALU takes the slot with rd=r, every stored live entry with rd=r is cleared to killed.
  - A same-cycle incoming load with rd=r is handshaken but enqueued as killed.
  - Rationale: an ALU result is always younger than any load accepted in the same or earlier cycle.
- Pointers: read/write pointers are log2(DEPTH)+1 bits.
  - full = MSBs differ and low bits are equal.
  - empty = pointers equal.
  - Wrap-around is natural.
- Hazard query: q_busyN=1 iff q_raN!=0 and some stored live entry has rd==q_raN.
  - The rf_* output stage is excluded, because the regfile bypasses same-cycle writes.
- Full FIFO: mem_ready=0; the load source holds mem_valid/mem_rd/mem_data stable until accepted.
- ALU saturation: continuous ALU traffic starves the FIFO. This is legal; the FIFO fills and mem_ready stays low.

Optional Feature:
- Macro: RF_WB_PERF_EN.
- Defined: adds output ports perf_kill_cnt (16 bits) and perf_stall_cnt (16 bits). Both reset to 0 and saturate at 0xFFFF.
  - perf_kill_cnt increments once per cycle in which at least one entry (stored or incoming) is killed.
  - perf_stall_cnt increments each cycle with mem_valid && !mem_ready.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then ALU alu_rd=3, data=0x11 for one cycle -> next cycle rf_we=1, rf_wa=3, rf_wd=0x11; the cycle after, rf_we=0.
- Push loads rd=5/0xA, rd=6/0xB while ALU idle -> written in order: rf_wa=5/0xA, then 6/0xB. q_busy1 for q_ra1=6 is 1 until the 6/0xB entry pops.
- Hold alu_valid=1 (rd=1) and push 4 loads (rd=7..10) -> mem_ready drops to 0 after the 4th push and mem_valid is held. Drop ALU -> loads drain in order, and mem_ready reasserts the cycle after the first pop.
- Queue load rd=9/0x99, then ALU rd=9/0x55 in the same cycle as an incoming load rd=9 -> only 0x55 is written to r9; both load slots are popped with rf_we=0; q_busy for 9 clears.
- mem_rd=0 handshake and alu_rd=0 -> rf_we stays 0; FIFO count unchanged; q_busy for 0 stays 0.
- Assert rst_n=0 asynchronously with 3 loads queued -> rf_we=0 immediately; after release, mem_ready=1 and no stale write appears. With RF_WB_PERF_EN defined, both counters read 0.

Source files
------------

// File: rtl/rf_writeback.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | rf_writeback: merges ALU and load results onto the regfile write port, |
// | queues loads in a FIFO and exposes pending-load hazard queries.        |
// | Optional macro RF_WB_PERF_EN adds kill/stall performance counters.     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module rf_writeback #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  input  logic [AW-1:0] q_ra1,
  input  logic [AW-1:0] q_ra2,
  output logic          q_busy1,
  output logic          q_busy2
`ifdef RF_WB_PERF_EN
  ,
  output logic [15:0]   perf_kill_cnt,
  output logic [15:0]   perf_stall_cnt
`endif
);

  localparam int c_IW = $clog2(DEPTH);
  localparam int c_PW = c_IW + 1;

  logic [AW-1:0]    r_rd   [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [DEPTH-1:0] r_live;
  logic [c_PW-1:0]  r_wptr;
  logic [c_PW-1:0]  r_rptr;

  logic [c_IW-1:0]  w_head;
  logic [c_IW-1:0]  w_tail;
  logic             w_full;
  logic             w_empty;
  logic             w_alu_take;
  logic             w_pop;
  logic             w_push;
  logic             w_in_kill;
  logic             w_head_live;
  logic [DEPTH-1:0] w_kill_vec;
  logic [DEPTH-1:0] w_live_nxt;

  assign w_head      = r_rptr[c_IW-1:0];
  assign w_tail      = r_wptr[c_IW-1:0];
  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (r_wptr[c_PW-1] != r_rptr[c_PW-1]) && (w_head == w_tail);
  assign mem_ready   = !w_full;

  assign w_alu_take  = alu_valid && (alu_rd != '0);
  assign w_pop       = !w_alu_take && !w_empty;
  assign w_push      = mem_valid && !w_full && (mem_rd != '0);
  // An ALU result is younger than any load accepted in the same cycle.
  assign w_in_kill   = w_push && w_alu_take && (mem_rd == alu_rd);
  assign w_head_live = r_live[w_head];

  always_comb begin
    w_kill_vec = '0;
    q_busy1    = 1'b0;
    q_busy2    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_alu_take && r_live[i] && (r_rd[i] == alu_rd)) w_kill_vec[i] = 1'b1;
      if ((q_ra1 != '0) && r_live[i] && (r_rd[i] == q_ra1)) q_busy1 = 1'b1;
      if ((q_ra2 != '0) && r_live[i] && (r_rd[i] == q_ra2)) q_busy2 = 1'b1;
    end
  end

  // Live bits are cleared on pop so stale slots never match a query.
  always_comb begin
    w_live_nxt = r_live & ~w_kill_vec;
    if (w_pop)  w_live_nxt[w_head] = 1'b0;
    if (w_push) w_live_nxt[w_tail] = !w_in_kill;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[w_tail]   <= mem_rd;
      r_data[w_tail] <= mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      rf_we  <= 1'b0;
      rf_wa  <= '0;
      rf_wd  <= '0;
    end else begin
      r_live <= w_live_nxt;
      if (w_push) r_wptr <= r_wptr + c_PW'(1);
      if (w_pop)  r_rptr <= r_rptr + c_PW'(1);
      rf_we <= w_alu_take || (w_pop && w_head_live);
      if (w_alu_take) begin
        rf_wa <= alu_rd;
        rf_wd <= alu_data;
      end else if (w_pop && w_head_live) begin
        rf_wa <= r_rd[w_head];
        rf_wd <= r_data[w_head];
      end
    end
  end

`ifdef RF_WB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_kill_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (((|w_kill_vec) || w_in_kill) && (perf_kill_cnt != 16'hFFFF))
        perf_kill_cnt <= perf_kill_cnt + 16'd1;
      if (mem_valid && w_full && (perf_stall_cnt != 16'hFFFF))
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_writeback.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_rf_writeback: directed plus random stimulus against a queue model.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_rf_writeback;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alu_valid = 1'b0;
  logic [AW-1:0] alu_rd = '0;
  logic [DW-1:0] alu_data = '0;
  logic          mem_valid = 1'b0;
  logic          mem_ready;
  logic [AW-1:0] mem_rd = '0;
  logic [DW-1:0] mem_data = '0;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic [AW-1:0] q_ra1 = '0;
  logic [AW-1:0] q_ra2 = '0;
  logic          q_busy1;
  logic          q_busy2;
`ifdef RF_WB_PERF_EN
  logic [15:0]   perf_kill_cnt;
  logic [15:0]   perf_stall_cnt;
`endif

  rf_writeback #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .q_ra1(q_ra1), .q_ra2(q_ra2), .q_busy1(q_busy1), .q_busy2(q_busy2)
`ifdef RF_WB_PERF_EN
    , .perf_kill_cnt(perf_kill_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    bit            live;
  } ent_t;

  ent_t          q[$];
  int            checks = 0;
  int            errors = 0;
  logic          exp_we = 1'b0;
  logic [AW-1:0] exp_wa = '0;
  logic [DW-1:0] exp_wd = '0;
  int            exp_kill = 0;
  int            exp_stall = 0;
  bit            accepted;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit busy(input logic [AW-1:0] a);
    if (a == '0) return 1'b0;
    foreach (q[i]) if (q[i].live && q[i].rd == a) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: check combinational outputs, advance model, check rf_* after the edge.
  task automatic step();
    ent_t h;
    bit take, rdy, push, kill_any, in_kill;
    @(negedge clk);
    rdy = (q.size() < DEPTH);
    check("mem_ready", 32'(mem_ready), 32'(rdy));
    check("q_busy1", 32'(q_busy1), 32'(busy(q_ra1)));
    check("q_busy2", 32'(q_busy2), 32'(busy(q_ra2)));
    take     = alu_valid && (alu_rd != '0);
    push     = mem_valid && rdy && (mem_rd != '0);
    accepted = mem_valid && rdy;
    in_kill  = push && take && (mem_rd == alu_rd);
    kill_any = in_kill;
    if (take) begin
      exp_we = 1'b1; exp_wa = alu_rd; exp_wd = alu_data;
      foreach (q[i]) if (q[i].live && q[i].rd == alu_rd) begin
        q[i].live = 1'b0;
        kill_any  = 1'b1;
      end
    end else if (q.size() > 0) begin
      h = q.pop_front();
      exp_we = h.live;
      if (h.live) begin exp_wa = h.rd; exp_wd = h.data; end
    end else begin
      exp_we = 1'b0;
    end
    if (push) q.push_back('{rd: mem_rd, data: mem_data, live: !in_kill});
    if (kill_any) exp_kill++;
    if (mem_valid && !rdy) exp_stall++;
    @(posedge clk);
    #1;
    check("rf_we", 32'(rf_we), 32'(exp_we));
    check("rf_wa", 32'(rf_wa), 32'(exp_wa));
    check("rf_wd", rf_wd, exp_wd);
`ifdef RF_WB_PERF_EN
    check("perf_kill", 32'(perf_kill_cnt), 32'(exp_kill));
    check("perf_stall", 32'(perf_stall_cnt), 32'(exp_stall));
`endif
  endtask

  task automatic load(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    int n = 0;
    mem_valid = 1'b1; mem_rd = rd; mem_data = d;
    do begin
      step();
      n++;
    end while (!accepted && n < 50);
    check("load_accept", 32'(accepted), 32'd1);
    mem_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_wa", 32'(rf_wa), 32'd0);
    check("rst_wd", rf_wd, 32'd0);
    check("rst_ready", 32'(mem_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single ALU write then idle
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    step();
    check("alu_wd_0x11", rf_wd, 32'h11);
    alu_valid = 1'b0;
    step();

    // Two loads drained in order, hazard tracked on r6
    q_ra1 = 5'd6;
    load(5'd5, 32'hA);
    load(5'd6, 32'hB);
    repeat (3) step();

    // ALU saturation fills the FIFO, then drains
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1234;
    for (int r = 7; r <= 10; r++) load(5'(r), 32'(r * 16));
    mem_valid = 1'b1; mem_rd = 5'd11; mem_data = 32'hCC;
    repeat (3) step();
    check("full_not_ready", 32'(mem_ready), 32'd0);
    alu_valid = 1'b0;
    load(5'd11, 32'hCC);
    repeat (6) step();

    // WAW kill of stored and incoming load to r9
    q_ra2 = 5'd9;
    alu_valid = 1'b1; alu_rd = 5'd1;
    load(5'd9, 32'h99);
    alu_rd = 5'd9; alu_data = 32'h55;
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h77;
    step();
    check("waw_wa", 32'(rf_wa), 32'd9);
    check("waw_wd", rf_wd, 32'h55);
    mem_valid = 1'b0; alu_valid = 1'b0;
    repeat (3) step();

    // x0 on both sources
    q_ra1 = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hBEEF;
    repeat (2) step();
    mem_valid = 1'b0; alu_valid = 1'b0;
    step();

    // Asynchronous reset with three loads queued
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
    load(5'd12, 32'h1);
    load(5'd13, 32'h2);
    load(5'd14, 32'h3);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_we", 32'(rf_we), 32'd0);
    check("async_rst_ready", 32'(mem_ready), 32'd1);
    q.delete();
    exp_we = 1'b0; exp_wa = '0; exp_wd = '0;
    exp_kill = 0; exp_stall = 0;
    alu_valid = 1'b0;
`ifdef RF_WB_PERF_EN
    check("rst_perf_kill", 32'(perf_kill_cnt), 32'd0);
    check("rst_perf_stall", 32'(perf_stall_cnt), 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) step();

    // Random traffic; load source holds until accepted
    for (int c = 0; c < 400; c++) begin
      alu_valid = 1'($urandom_range(0, 1));
      alu_rd    = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      q_ra1     = 5'($urandom_range(0, 7));
      q_ra2     = 5'($urandom_range(0, 7));
      if (!mem_valid && ($urandom_range(0, 3) != 0)) begin
        mem_valid = 1'b1;
        mem_rd    = 5'($urandom_range(0, 7));
        mem_data  = $urandom;
      end
      step();
      if (accepted) mem_valid = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
